// File: rtl/rvh_l1d_pkg.sv
// Shared L1D types and constants for the MSHR file and its fetch queue.
// Line address = {tag, bank set index}; priority encoder is shared here.
package rvh_l1d_pkg;

    localparam int PADDR_W                  = 32;
    localparam int L1D_BANK_OFFSET_WIDTH    = 6;
    localparam int L1D_BANK_SET_INDEX_WIDTH = 6;
    localparam int L1D_TAG_W                = PADDR_W - L1D_BANK_OFFSET_WIDTH
                                              - L1D_BANK_SET_INDEX_WIDTH;
    localparam int LINE_ADDR_W              = L1D_TAG_W + L1D_BANK_SET_INDEX_WIDTH;

    localparam int BURST_SIZE = 2;
    localparam int AXI_SIZE   = 5;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int MEMNOC_TID_MASTERID_SIZE = 4;
    localparam int MEMNOC_TID_TID_SIZE      = 8;

    // Widest vector the shared priority encoder accepts
    localparam int MSHR_MAX   = 64;
    localparam int MSHR_MAX_W = 6;

    typedef struct packed {
        logic [L1D_TAG_W-1:0]                new_tag;
        logic [L1D_BANK_SET_INDEX_WIDTH-1:0] bank_index;
        logic                                is_store;
        logic [7:0]                          lsu_tag;
        logic                                flush;
        logic                                no_write_alloc;
    } mshr_t;

    typedef struct packed {
        logic [MEMNOC_TID_MASTERID_SIZE-1:0] bid;
        logic [MEMNOC_TID_TID_SIZE-1:0]      tid;
    } mem_tid_t;

    typedef struct packed {
        mem_tid_t           arid;
        logic [PADDR_W-1:0] araddr;
        logic [7:0]         arlen;
        logic [2:0]         arsize;
        logic [1:0]         arburst;
    } cache_mem_if_ar_t;

    // Index of the lowest set bit; 0 when no bit is set
    function automatic logic [MSHR_MAX_W-1:0] lowest_set(
        input logic [MSHR_MAX-1:0] v
    );
        lowest_set = '0;
        for (int i = MSHR_MAX - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = i[MSHR_MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/rvh_l1d_mshr_fetch_q.sv
// Age-ordered FIFO of MSHR ids waiting to issue a line fetch.
// Depth equals the entry count, so pushes never find it full.
module rvh_l1d_mshr_fetch_q #(
    parameter int DEPTH = 8,
    parameter int W     = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_id_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] wr_ptr_q;
    logic [W-1:0] rd_ptr_q;
    logic [W:0]   cnt_q;

    function automatic logic [W-1:0] ptr_inc(input logic [W-1:0] p);
        ptr_inc = (p == W'(DEPTH - 1)) ? '0 : p + W'(1);
    endfunction

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (cnt_q == '0);

    // Pointer and occupancy update; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Id storage, needs no reset since occupancy gates reads
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/rvh_l1d_mshr_file.sv
// L1D miss-status holding register file for one D$ bank.
// Optional line-address lookup: RVH_L1D_MSHR_ADDR_MATCH_EN.
module rvh_l1d_mshr_file
    import rvh_l1d_pkg::*;
#(
    parameter int N_ENTRY = 8,
    parameter int N_ID_W  = $clog2(N_ENTRY),
    parameter int BANK_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid_i,
    output logic                   alloc_ready_o,
    input  mshr_t                  alloc_i,
    output logic [N_ID_W-1:0]      alloc_id_o,
    input  logic                   lookup_valid_i,
    input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
    output logic                   lookup_hit_o,
    output logic [N_ID_W-1:0]      lookup_hit_id_o,
    input  logic                   dealloc_valid_i,
    input  logic [N_ID_W-1:0]      dealloc_id_i,
    output logic                   dealloc_ready_o,
    output logic                   l2_req_if_arvalid,
    input  logic                   l2_req_if_arready,
    output cache_mem_if_ar_t       l2_req_if_ar,
    input  logic                   rob_flush_i,
    output mshr_t                  mshr_bank_o [N_ENTRY],
    output logic [N_ENTRY-1:0]     mshr_bank_valid_o,
    output logic [N_ENTRY-1:0]     mshr_bank_no_resp_o,
    output logic [N_ENTRY-1:0]     mshr_bank_sent_o
);

    localparam logic [31:0] BANK_ID_L = BANK_ID;
    localparam logic [MEMNOC_TID_MASTERID_SIZE-1:0] BID =
        {1'b0, BANK_ID_L[MEMNOC_TID_MASTERID_SIZE-2:0]};

    logic [N_ENTRY-1:0] valid_q;
    logic [N_ENTRY-1:0] sent_q;
    logic [N_ENTRY-1:0] no_resp_q;
    mshr_t              bank_q [N_ENTRY];

    logic [MSHR_MAX-1:0] free_ext;
    logic                alloc_fire;
    logic                need_fetch;
    logic                ar_fire;
    logic                dealloc_ok;
    logic                q_empty;
    logic [N_ID_W-1:0]   head_id;

    // Free vector widened for the shared encoder
    always_comb begin
        free_ext               = '0;
        free_ext[N_ENTRY-1:0]  = ~valid_q;
    end

    assign alloc_ready_o   = |(~valid_q);
    assign alloc_id_o      = N_ID_W'(lowest_set(free_ext));
    assign alloc_fire      = alloc_valid_i & alloc_ready_o;
    assign need_fetch      = ~alloc_i.flush & ~alloc_i.no_write_alloc;
    assign dealloc_ready_o = 1'b1;
    assign dealloc_ok      = dealloc_valid_i & valid_q[dealloc_id_i]
                             & sent_q[dealloc_id_i];

    assign l2_req_if_arvalid = ~q_empty;
    assign ar_fire           = l2_req_if_arvalid & l2_req_if_arready;

    rvh_l1d_mshr_fetch_q #(
        .DEPTH (N_ENTRY),
        .W     (N_ID_W)
    ) u_fetch_q (
        .clk       (clk),
        .rst       (rst),
        .push_i    (alloc_fire & need_fetch),
        .push_id_i (alloc_id_o),
        .pop_i     (ar_fire),
        .head_o    (head_id),
        .empty_o   (q_empty)
    );

    // AR payload built from the oldest queued entry
    always_comb begin
        l2_req_if_ar          = '0;
        l2_req_if_ar.arid.bid = BID;
        l2_req_if_ar.arid.tid = MEMNOC_TID_TID_SIZE'(head_id);
        l2_req_if_ar.araddr   = {bank_q[head_id].new_tag,
                                 bank_q[head_id].bank_index,
                                 {L1D_BANK_OFFSET_WIDTH{1'b0}}};
        l2_req_if_ar.arlen    = 8'(BURST_SIZE - 1);
        l2_req_if_ar.arsize   = 3'(AXI_SIZE);
        l2_req_if_ar.arburst  = AXI_BURST_INCR;
    end

    // Per-entry status; flush set overrides the allocation clear
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            sent_q    <= '0;
            no_resp_q <= '0;
        end else begin
            for (int i = 0; i < N_ENTRY; i++) begin
                if (alloc_fire && alloc_id_o == N_ID_W'(i)) begin
                    valid_q[i]   <= 1'b1;
                    sent_q[i]    <= ~need_fetch;
                    no_resp_q[i] <= 1'b0;
                end
                if (ar_fire && head_id == N_ID_W'(i)) sent_q[i] <= 1'b1;
                if (dealloc_ok && dealloc_id_i == N_ID_W'(i)) valid_q[i] <= 1'b0;
                if (rob_flush_i) no_resp_q[i] <= 1'b1;
            end
        end
    end

    // Entry payload capture on grant
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_ENTRY; i++) begin
            if (alloc_fire && alloc_id_o == N_ID_W'(i)) bank_q[i] <= alloc_i;
        end
    end

    assign mshr_bank_o         = bank_q;
    assign mshr_bank_valid_o   = valid_q;
    assign mshr_bank_sent_o    = sent_q;
    assign mshr_bank_no_resp_o = no_resp_q;

`ifdef RVH_L1D_MSHR_ADDR_MATCH_EN
    logic [MSHR_MAX-1:0] hit_ext;

    // Line-address compare against registered valid entries
    always_comb begin
        hit_ext = '0;
        for (int i = 0; i < N_ENTRY; i++) begin
            hit_ext[i] = lookup_valid_i & valid_q[i]
                         & ({bank_q[i].new_tag, bank_q[i].bank_index}
                            == lookup_addr_i);
        end
    end

    assign lookup_hit_o    = |hit_ext;
    assign lookup_hit_id_o = N_ID_W'(lowest_set(hit_ext));

    a_single_hit: assert property (
        @(posedge clk) disable iff (rst) $onehot0(hit_ext)
    );
`else
    logic unused_lookup;
    assign unused_lookup   = ^{lookup_valid_i, lookup_addr_i};
    assign lookup_hit_o    = 1'b0;
    assign lookup_hit_id_o = '0;
`endif

    a_dealloc_legal: assert property (
        @(posedge clk) disable iff (rst)
        dealloc_valid_i |-> (valid_q[dealloc_id_i] && sent_q[dealloc_id_i])
    );

endmodule

// File: tb/tb_rvh_l1d_mshr_file.sv
// Randomised bench for rvh_l1d_mshr_file against an array/queue model.
// Lookup expectations follow RVH_L1D_MSHR_ADDR_MATCH_EN.
module tb_rvh_l1d_mshr_file;
    import rvh_l1d_pkg::*;

    localparam int N  = 8;
    localparam int IW = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   alloc_valid;
    logic                   alloc_ready;
    mshr_t                  alloc_pay;
    logic [IW-1:0]          alloc_id;
    logic                   lookup_valid;
    logic [LINE_ADDR_W-1:0] lookup_addr;
    logic                   lookup_hit;
    logic [IW-1:0]          lookup_hit_id;
    logic                   dealloc_valid;
    logic [IW-1:0]          dealloc_id;
    logic                   dealloc_ready;
    logic                   arvalid;
    logic                   arready;
    cache_mem_if_ar_t       ar;
    logic                   rob_flush;
    mshr_t                  dut_bank [N];
    logic [N-1:0]           dut_valid;
    logic [N-1:0]           dut_no_resp;
    logic [N-1:0]           dut_sent;

    always #5 clk = ~clk;

    rvh_l1d_mshr_file #(.N_ENTRY(N), .N_ID_W(IW), .BANK_ID(0)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_valid_i       (alloc_valid),
        .alloc_ready_o       (alloc_ready),
        .alloc_i             (alloc_pay),
        .alloc_id_o          (alloc_id),
        .lookup_valid_i      (lookup_valid),
        .lookup_addr_i       (lookup_addr),
        .lookup_hit_o        (lookup_hit),
        .lookup_hit_id_o     (lookup_hit_id),
        .dealloc_valid_i     (dealloc_valid),
        .dealloc_id_i        (dealloc_id),
        .dealloc_ready_o     (dealloc_ready),
        .l2_req_if_arvalid   (arvalid),
        .l2_req_if_arready   (arready),
        .l2_req_if_ar        (ar),
        .rob_flush_i         (rob_flush),
        .mshr_bank_o         (dut_bank),
        .mshr_bank_valid_o   (dut_valid),
        .mshr_bank_no_resp_o (dut_no_resp),
        .mshr_bank_sent_o    (dut_sent)
    );

    int total = 0;
    int bad   = 0;

    // Reference state: entry table plus a plain queue of ids awaiting AR
    mshr_t m_pay   [N];
    bit    m_valid [N];
    bit    m_sent  [N];
    bit    m_nr    [N];
    int    m_q     [$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int first_free();
        for (int i = 0; i < N; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic logic [LINE_ADDR_W-1:0] line_of(input mshr_t p);
        return {p.new_tag, p.bank_index};
    endfunction

    function automatic cache_mem_if_ar_t exp_ar(input int id);
        cache_mem_if_ar_t e;
        e          = '0;
        e.arid.bid = 4'b0000;
        e.arid.tid = 8'(id);
        e.araddr   = {m_pay[id].new_tag, m_pay[id].bank_index, 6'b0};
        e.arlen    = 8'd1;
        e.arsize   = 3'd5;
        e.arburst  = 2'b01;
        return e;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0;
            m_sent[i]  = 0;
            m_nr[i]    = 0;
        end
        m_q.delete();
    endtask

    task automatic idle_inputs();
        alloc_valid   = 0;
        alloc_pay     = '0;
        lookup_valid  = 0;
        lookup_addr   = '0;
        dealloc_valid = 0;
        dealloc_id    = '0;
        rob_flush     = 0;
    endtask

    // Random payload whose line address is not already held by a valid entry
    task automatic set_alloc(input bit v, input bit fl, input bit nwa);
        mshr_t p;
        bit    clash;
        int    tries = 0;
        do begin
            p            = '0;
            p.new_tag    = 20'($urandom);
            p.bank_index = 6'($urandom);
            clash        = 0;
            for (int i = 0; i < N; i++)
                if (m_valid[i] && line_of(m_pay[i]) == line_of(p)) clash = 1;
            tries++;
        end while (clash && tries < 100);
        p.is_store       = 1'($urandom);
        p.lsu_tag        = 8'($urandom);
        p.flush          = fl;
        p.no_write_alloc = nwa;
        alloc_pay        = p;
        alloc_valid      = v;
    endtask

    // Compare DUT against the model, then advance both by one edge
    task automatic cycle();
        int           ff;
        int           hid;
        bit           hit;
        bit           a_fire;
        bit           ar_f;
        bit           d_ok;
        logic [N-1:0] ev;
        logic [N-1:0] es;
        logic [N-1:0] en;
        #1;
        ff = first_free();
        check("alloc_ready", 64'(alloc_ready), 64'(ff >= 0));
        if (ff >= 0) check("alloc_id", 64'(alloc_id), 64'(ff));
        check("dealloc_ready", 64'(dealloc_ready), 64'(1));
        check("arvalid", 64'(arvalid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) check("ar_payload", 64'(ar), 64'(exp_ar(m_q[0])));
        for (int i = 0; i < N; i++) begin
            ev[i] = m_valid[i];
            es[i] = m_sent[i];
            en[i] = m_nr[i];
        end
        check("valid", 64'(dut_valid), 64'(ev));
        check("sent", 64'(dut_sent), 64'(es));
        check("no_resp", 64'(dut_no_resp), 64'(en));
        for (int i = 0; i < N; i++)
            if (m_valid[i]) check("payload", 64'(dut_bank[i]), 64'(m_pay[i]));
        hit = 0;
        hid = 0;
`ifdef RVH_L1D_MSHR_ADDR_MATCH_EN
        if (lookup_valid)
            for (int i = 0; i < N; i++)
                if (!hit && m_valid[i] && line_of(m_pay[i]) == lookup_addr) begin
                    hit = 1;
                    hid = i;
                end
`endif
        check("lookup_hit", 64'(lookup_hit), 64'(hit));
        check("lookup_id", 64'(lookup_hit_id), 64'(hid));

        a_fire = !rst && alloc_valid && ff >= 0;
        ar_f   = !rst && arready && m_q.size() != 0;
        d_ok   = !rst && dealloc_valid && m_valid[dealloc_id] && m_sent[dealloc_id];
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (ar_f) m_sent[m_q.pop_front()] = 1;
            if (d_ok) m_valid[dealloc_id] = 0;
            if (a_fire) begin
                m_valid[ff] = 1;
                m_pay[ff]   = alloc_pay;
                m_nr[ff]    = 0;
                m_sent[ff]  = alloc_pay.flush || alloc_pay.no_write_alloc;
                if (!m_sent[ff]) m_q.push_back(ff);
            end
            if (rob_flush) for (int i = 0; i < N; i++) m_nr[i] = 1;
        end
        @(negedge clk);
    endtask

    initial begin
        int cand [$];
        rst     = 1;
        arready = 0;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_alloc_ready", 64'(alloc_ready), 64'(1));
        check("rst_lookup_hit", 64'(lookup_hit), 64'(0));
        check("rst_valid", 64'(dut_valid), 64'(0));
        check("rst_sent", 64'(dut_sent), 64'(0));
        check("rst_no_resp", 64'(dut_no_resp), 64'(0));

        // Eight back-to-back read misses with AR always ready
        arready = 1;
        for (int i = 0; i < 8; i++) begin
            set_alloc(1, 0, 0);
            cycle();
        end
        alloc_valid = 0;
        repeat (3) cycle();
        for (int i = 0; i < N; i++) begin
            dealloc_valid = 1;
            dealloc_id    = IW'(i);
            cycle();
        end
        dealloc_valid = 0;

        // Back-pressure with three queued fetches
        arready = 0;
        for (int i = 0; i < 3; i++) begin
            set_alloc(1, 0, 0);
            cycle();
        end
        alloc_valid = 0;
        repeat (5) cycle();
        arready = 1;
        repeat (4) cycle();

        // Allocations needing no fetch
        set_alloc(1, 1, 0);
        cycle();
        set_alloc(1, 0, 1);
        cycle();
        alloc_valid = 0;
        repeat (2) cycle();

        // Fill, then free id 3 while an alloc waits
        while (first_free() >= 0) begin
            set_alloc(1, 0, 0);
            cycle();
        end
        alloc_valid = 0;
        repeat (4) cycle();
        dealloc_valid = 1;
        dealloc_id    = 3'd3;
        set_alloc(1, 0, 0);
        cycle();
        dealloc_valid = 0;
        cycle();
        alloc_valid = 0;
        repeat (2) cycle();

        // ROB flush coinciding with the allocation of id 2
        dealloc_valid = 1;
        dealloc_id    = 3'd2;
        cycle();
        dealloc_valid = 0;
        set_alloc(1, 0, 0);
        rob_flush = 1;
        cycle();
        alloc_valid = 0;
        rob_flush   = 0;
        repeat (2) cycle();

        // Lookup of entry 5 before and after its release
        lookup_valid = 1;
        lookup_addr  = line_of(m_pay[5]);
        cycle();
        dealloc_valid = 1;
        dealloc_id    = 3'd5;
        cycle();
        dealloc_valid = 0;
        cycle();
        lookup_valid = 0;

        // Reset while a fetch is presented
        arready = 0;
        set_alloc(1, 0, 0);
        cycle();
        alloc_valid = 0;
        cycle();
        rst     = 1;
        arready = 1;
        cycle();
        rst = 0;
        repeat (2) cycle();

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            set_alloc($urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                      $urandom_range(0, 7) == 0);
            arready   = $urandom_range(0, 3) != 0;
            rob_flush = $urandom_range(0, 15) == 0;
            cand.delete();
            for (int i = 0; i < N; i++)
                if (m_valid[i] && m_sent[i]) cand.push_back(i);
            dealloc_valid = 0;
            if (cand.size() != 0 && $urandom_range(0, 1) == 1) begin
                dealloc_valid = 1;
                dealloc_id    = IW'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            lookup_valid = $urandom_range(0, 1) == 1;
            lookup_addr  = LINE_ADDR_W'($urandom);
            if ($urandom_range(0, 1) == 1)
                lookup_addr = line_of(m_pay[$urandom_range(0, N - 1)]);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
